mem_port_arbiter: RTL

- Shares one single-ported memory instance between the processor's instruction-fetch port (read-only) and its data port (read/write).
- This lets the processor run from a unified memory instead of separate instruction and data memory instances.
- Captures requests, sequences each access through the memory port, and returns a one-cycle response pulse to the winning requester.
- Data port has priority, bounded by an anti-starvation counter for fetch.

---
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between an instruction-fetch port (read-only)
// and a data port (read/write). Data has priority; a streak counter caps how
// many data grants in a row can pass a waiting fetch.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // request captured in the grant cycle; the memory port is driven from it
  typedef struct packed {
    logic              sel_f;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state, state_nxt;
  req_t              cap, cap_nxt;
  logic [3:0]        streak, streak_nxt;
  logic [DATA_W-1:0] rdata_q;

  // arbitration in IDLE/RESP, next-state and capture of the winner
  always_comb begin
    state_nxt  = state;
    cap_nxt    = cap;
    streak_nxt = streak;
    f_gnt      = 1'b0;
    d_gnt      = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (f_req && (!d_req || streak == STREAK_MAX)) f_gnt = 1'b1;
        else if (d_req)                                d_gnt = 1'b1;
        if (f_gnt || d_gnt) begin
          state_nxt     = ACCESS;
          cap_nxt.sel_f = f_gnt;
          cap_nxt.we    = d_gnt & d_we;
          cap_nxt.addr  = f_gnt ? f_addr : d_addr;
          // fetch has no write data; keep the last value on the port
          cap_nxt.wdata = f_gnt ? cap.wdata : d_wdata;
        end else begin
          state_nxt = IDLE;
        end
        if (f_gnt)                                      streak_nxt = '0;
        else if (d_gnt && f_req && streak < STREAK_MAX) streak_nxt = streak + 4'd1;
      end
      ACCESS:  state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      f_gnt = 1'b0;
      d_gnt = 1'b0;
    end
  end

  // state, capture, streak and read-data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cap     <= '0;
      streak  <= '0;
      rdata_q <= '0;
    end else begin
      state  <= state_nxt;
      cap    <= cap_nxt;
      streak <= streak_nxt;
      if (state == ACCESS) rdata_q <= cap.we ? '0 : mem_rdata;
    end
  end

  // address/data hold the last captured request outside ACCESS
  assign mem_addr  = cap.addr;
  assign mem_wdata = cap.wdata;
  assign mem_we    = (state == ACCESS) & cap.we & ~rst;
  assign rdata     = rdata_q;
  assign f_rvalid  = (state == RESP) &  cap.sel_f & ~rst;
  assign d_rvalid  = (state == RESP) & ~cap.sel_f & ~rst;
  assign busy      = (state != IDLE);

endmodule
